// File: rtl/mdu_iter_if.sv
// Handshake and result bundle for the iterative multiply/divide unit.
// The master (EX stage) drives the request and flush lines.
// The slave (mdu_iter) returns ready/valid and the HI/LO result pair.
interface mdu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  ready, valid, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output ready, valid, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: multi-cycle multiply/divide unit feeding the HI/LO register pair.
// Operations: MULT, MULTU, DIV, DIVU.
//   - Products are written as {hi,lo}.
//   - Quotients go to lo and remainders go to hi.
// Signed operations run on magnitudes, and the result signs are fixed up
// at the end.
// Optional build macro MDU_FAST_MULT_EN: multiplies are computed in a single
// combinational step (IDLE -> FIX -> DONE). Divide always stays iterative.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  mdu_iter_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  state_e             state_q, state_d;
  logic               is_div_q, is_div_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic               sgn_op;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     shifted;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   remv;

  assign abs_a  = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign abs_b  = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign sgn_op = ~bus.op[0];

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, opb_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`endif

  assign bus.ready = (state_q == IDLE);
  assign bus.valid = (state_q == DONE);
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  // Next-state and datapath logic; flush from any busy state overrides everything but reset
  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mul_sum  = '0;
    shifted  = '0;
    prod     = '0;
    quo      = '0;
    remv     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          is_div_d = bus.op[1];
          cnt_d    = '0;
          rem_d    = '0;
          if (bus.op[1]) begin
            if (bus.b == '0) begin
              // A zero divisor makes every trial subtract succeed. The quotient
              // therefore becomes all ones and the dividend shifts unchanged
              // into the remainder. Latch the raw dividend and skip any sign fix.
              acc_d  = {{WIDTH{1'b0}}, bus.a};
              opb_d  = '0;
              neg_d  = 1'b0;
              rneg_d = 1'b0;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, (sgn_op ? abs_a : bus.a)};
              opb_d  = sgn_op ? abs_b : bus.b;
              neg_d  = sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              rneg_d = sgn_op & bus.a[WIDTH-1];
            end
            state_d = CALC;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, (sgn_op ? abs_b : bus.b)};
            opb_d  = sgn_op ? abs_a : bus.a;
            neg_d  = sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rneg_d = 1'b0;
`ifdef MDU_FAST_MULT_EN
            state_d = FIX;
`else
            state_d = CALC;
`endif
          end
        end
      end
      CALC: begin
        if (is_div_q) begin
          shifted = {rem_q, acc_q[WIDTH-1]};
          if (shifted >= {1'b0, opb_q}) begin
            rem_d            = WIDTH'(shifted - {1'b0, opb_q});
            acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d            = shifted[WIDTH-1:0];
            acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
          acc_d   = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        if (is_div_q) begin
          quo  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          remv = rneg_q ? -rem_q : rem_q;
          hi_d = remv;
          lo_d = quo;
        end else begin
`ifdef MDU_FAST_MULT_EN
          prod = fast_prod;
`else
          prod = acc_q;
`endif
          if (neg_q) begin
            prod = -prod;
          end
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.flush && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Testbench for mdu_iter (WIDTH=32).
// Results are compared against a plain-arithmetic reference model.
// Also covers flush, ignored start, reset mid-operation and random operands.
module tb_mdu_iter;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  mdu_iter_if #(.WIDTH(W)) bus ();

  mdu_iter #(.WIDTH(W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model from the arithmetic definition of each operation
  function automatic void refModel(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo);
    logic signed [63:0] sp;
    logic [63:0] up;
    int sa, sb, sq, sr;
    hi = '0;
    lo = '0;
    case (op)
      OP_MULT: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        hi = sp[63:32];
        lo = sp[31:0];
      end
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      OP_DIV: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000;
          hi = 32'h0;
        end else begin
          sa = a;
          sb = b;
          sq = sa / sb;
          sr = sa % sb;
          lo = sq;
          hi = sr;
        end
      end
      default: begin
        if (b == 0) begin
          lo = 32'hFFFF_FFFF;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
  endtask

  // Full operation: start, optional intruding start, wait for valid, check.
  task automatic runOp(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int intrude);
    logic [W-1:0] eh, el;
    int cyc, lat_exp;
    bit seen;
    refModel(op, a, b, eh, el);
    lat_exp = W + 2;
`ifdef MDU_FAST_MULT_EN
    if (!op[1]) lat_exp = 2;
`endif
    applyStimulus(op, a, b);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        checkOutput({tag, "/ready_busy"}, W'(bus.ready), 32'd0);
      end
      if (intrude != 0 && cyc == intrude) begin
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.a     = 32'd9;
        bus.b     = 32'd3;
      end
      if (intrude != 0 && cyc == intrude + 1) bus.start = 1'b0;
      if (bus.valid) seen = 1;
    end
    checkOutput({tag, "/latency"}, W'(cyc), W'(lat_exp));
    checkOutput({tag, "/hi"}, bus.hi, eh);
    checkOutput({tag, "/lo"}, bus.lo, el);
    @(negedge clk);
    checkOutput({tag, "/valid_drop"}, W'(bus.valid), 32'd0);
    checkOutput({tag, "/ready_back"}, W'(bus.ready), 32'd1);
    exp_hi = eh;
    exp_lo = el;
  endtask

  initial begin
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    int vcount;
    checks    = 0;
    failures  = 0;
    exp_hi    = '0;
    exp_lo    = '0;
    rst       = 1'b0;
    bus.start = 1'b1;
    bus.op    = OP_MULT;
    bus.a     = 32'h1234_5678;
    bus.b     = 32'h9ABC_DEF0;
    bus.flush = 1'b0;

    $display("[TB] reset with start held high");
    repeat (3) @(negedge clk);
    checkOutput("reset/ready", W'(bus.ready), 32'd1);
    checkOutput("reset/valid", W'(bus.valid), 32'd0);
    checkOutput("reset/hi", bus.hi, 32'd0);
    checkOutput("reset/lo", bus.lo, 32'd0);
    bus.start = 1'b0;
    rst       = 1'b1;
    @(negedge clk);

    $display("[TB] directed operations");
    runOp("mult_m1x2", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    checkOutput("mult_m1x2/plan_hi", exp_hi, 32'hFFFF_FFFF);
    checkOutput("mult_m1x2/plan_lo", exp_lo, 32'hFFFF_FFFE);
    runOp("multu_m1x2", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 0);
    runOp("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    runOp("divu_7_2", OP_DIVU, 32'd7, 32'd2, 0);
    runOp("divu_5_0", OP_DIVU, 32'd5, 32'd0, 0);
    runOp("div_m9_0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 0);
    runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    runOp("mult_m1xm1", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    runOp("div_100_m7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 0);

    $display("[TB] hold between operations");
    repeat (5) @(negedge clk);
    checkOutput("hold/hi", bus.hi, exp_hi);
    checkOutput("hold/lo", bus.lo, exp_lo);

    $display("[TB] flush mid-calculation");
    applyStimulus(OP_MULTU, 32'd3, 32'd4);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 10) bus.flush = 1'b1;
    end
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush/ready", W'(bus.ready), 32'd1);
    checkOutput("flush/valid", W'(bus.valid), 32'd0);
    checkOutput("flush/hi", bus.hi, exp_hi);
    checkOutput("flush/lo", bus.lo, exp_lo);
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.valid) vcount++;
    end
    checkOutput("flush/no_valid", W'(vcount), 32'd0);
    runOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 0);

    $display("[TB] start while busy is ignored");
    runOp("mult_2x3_intrude", OP_MULT, 32'd2, 32'd3, 5);
    checkOutput("intrude/plan_lo", exp_lo, 32'd6);

    $display("[TB] flush and start together in idle");
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = OP_MULTU;
    bus.a     = 32'd7;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checkOutput("idle_flush/ready", W'(bus.ready), 32'd1);

    $display("[TB] reset mid-calculation");
    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 8) rst = 1'b0;
    end
    @(negedge clk);
    checkOutput("midrst/ready", W'(bus.ready), 32'd1);
    checkOutput("midrst/valid", W'(bus.valid), 32'd0);
    checkOutput("midrst/hi", bus.hi, 32'd0);
    checkOutput("midrst/lo", bus.lo, 32'd0);
    rst    = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);

    $display("[TB] random operations");
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = -32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      runOp("random", rop, ra, rb, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised, multi-cycle multiply/divide unit for the EX stage. Successor to the single-cycle combinational multiplier.
- Adds signed/unsigned division, a start/ready/valid handshake and a pipeline flush input.
- Results go to the HI/LO register pair: product as {hi,lo}, or quotient in lo and remainder in hi.
- The pipeline stalls EX while ready is low.

Parameters:
- WIDTH, 32, operand width in bits; must be an even number ≥4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset, sampled on the rising edge of clk).
- start  input  1  request; accepted only when ready=1.
- op  input  2  operation, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  multiplicand / dividend, sampled with start.
- b  input  WIDTH  multiplier / divisor, sampled with start.
- flush  input  1  abort any in-flight operation.
- ready  output  1  high in IDLE only.
- valid  output  1  one-cycle pulse when hi/lo are updated.
- hi  output  WIDTH  product upper half / remainder.
- lo  output  WIDTH  product lower half / quotient.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE, ready=1, valid=0, hi=0, lo=0, counter=0.
  - Reset overrides flush and start, and aborts any operation.
- State machine: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0: latch op.
  - Latch |a| and |b| for signed ops, raw values for unsigned ops.
  - Record result signs: product sign = a[W-1]^b[W-1]; quotient sign = a^b sign; remainder sign = a sign.
  - Clear counter; go to CALC.
- CALC:
  - One radix-2 step per cycle for exactly WIDTH cycles, counter 0..WIDTH-1, then go to FIX.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring divide; partial remainder is WIDTH+1 bits.
- FIX:
  - Two's-complement negate product, quotient and/or remainder per the recorded signs.
  - Write hi/lo; go to DONE.
- DONE: valid=1 for this cycle only; go to IDLE.
- Latency: start sampled in cycle 0 → valid in cycle WIDTH+2 (cycle 34 for WIDTH=32). ready is low in cycles 1..WIDTH+2.
- hi/lo change only in FIX and hold between operations.
- start while ready=0: ignored, with no effect on the in-flight operation.
- flush=1 in any state except IDLE: next state IDLE.
  - valid not asserted; hi/lo keep their previous values.
  - Counter cleared.
- flush and start in the same IDLE cycle: flush wins and the request is dropped.
- Divide by zero (b=0), both DIV and DIVU: lo = all ones, hi = dividend a (raw, unsigned interpretation of a). Latency unchanged.
- Signed overflow (DIV of most-negative by -1): lo = most-negative value, hi = 0. No trap.
- Remainder sign always follows the dividend; quotient truncates toward zero.
- All arithmetic is modulo 2^WIDTH per half; no output exceeds WIDTH bits.

Optional Feature:
- Macro: MDU_FAST_MULT_EN.
- Defined:
  - MULT/MULTU compute the 2*WIDTH product combinationally from the latched operands.
  - Skip CALC: IDLE → FIX → DONE, so valid is in cycle 2 after start.
  - Divide is unchanged.
- Undefined:
  - All ops use the iterative path.
  - No WIDTH×WIDTH multiplier is synthesised.
- Flush and handshake rules are identical in both builds.

Test Plan:
1. WIDTH=32, MULT a=0xFFFFFFFF b=0x00000002 → valid in cycle 34 exactly, hi=0xFFFFFFFF lo=0xFFFFFFFE, valid low in cycle 35. MULTU same operands → hi=0x00000001 lo=0xFFFFFFFE.
2. DIV a=0xFFFFFFF9 (-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 → lo=3, hi=1.
3. DIVU a=5 b=0 → lo=0xFFFFFFFF, hi=0x00000005 in cycle 34. DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000, hi=0.
4. MULTU 3×4 started; flush in cycle 10 → ready=1 in cycle 11, no valid pulse, hi/lo retain prior values. Then DIVU 100/7 → lo=14, hi=2, valid 34 cycles after its start.
5. Start MULT 2×3; pulse start with DIVU 9/3 in cycle 5 → second request ignored, result hi=0 lo=6. Then assert rst=0 mid-CALC of a new op → next cycle ready=1, valid=0, hi=lo=0.
6. Build with MDU_FAST_MULT_EN: MULT 0xFFFFFFFF×0xFFFFFFFF → hi=0 lo=1 with valid in cycle 2. DIV 100/7 still takes 34 cycles.
